// File: rtl/shift_frame_arbiter.sv
// shift_frame_arbiter: round-robin arbiter between two valid/ready requesters
// that serializes the granted word MSB-first onto shift_in, one bit per clock,
// with frame_active/done flags and GAP idle cycles between frames.
// Optional build macro SHIFT_FRAME_PARITY_EN appends an even-parity bit to
// every frame and moves done onto that bit.
module shift_frame_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             shift_in,
    output logic             frame_active,
    output logic             grant,
    output logic             done
);

`ifdef SHIFT_FRAME_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int GAP_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_buf;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             sel0;
    logic             sel1;
    logic             accept;
    logic             final_bit;
    logic             next_bit;
    logic [WIDTH-1:0] data_sel;
`ifdef SHIFT_FRAME_PARITY_EN
    logic             parity_q;
`endif

    // bit_cnt indexes the bit currently on shift_in
    assign bit_cnt_inc = bit_cnt + 1'b1;
    assign final_bit   = (bit_cnt == LAST_BIT);
    assign data_sel    = sel1 ? req1_data : req0_data;

    // shift_buf runs one bit ahead of shift_in because shift_in is registered;
    // with parity, the slot after the last data bit carries the parity bit
`ifdef SHIFT_FRAME_PARITY_EN
    assign next_bit = (bit_cnt_inc == CNT_W'(WIDTH)) ? parity_q : shift_buf[WIDTH-1];
`else
    assign next_bit = shift_buf[WIDTH-1];
`endif

    // Round-robin pick: a lone requester wins, a contest goes to the one not granted last
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (req0_valid && req1_valid) begin
            sel0 = last_grant;
            sel1 = !last_grant;
        end else begin
            sel0 = req0_valid;
            sel1 = req1_valid;
        end
    end

    // Next-state logic and the combinational ready handshake (held off during reset)
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    req0_ready = sel0;
                    req1_ready = sel1;
                    accept     = sel0 || sel1;
                end
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (final_bit) begin
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered frame outputs, bit/gap counters and arbitration history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_in     <= 1'b0;
            frame_active <= 1'b0;
            done         <= 1'b0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant        <= sel1;
                        last_grant   <= sel1;
                        bit_cnt      <= '0;
                        shift_in     <= data_sel[WIDTH-1];
                        frame_active <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (final_bit) begin
                        shift_in     <= 1'b0;
                        frame_active <= 1'b0;
                        done         <= 1'b0;
                        gap_cnt      <= '0;
                    end else begin
                        bit_cnt  <= bit_cnt_inc;
                        shift_in <= next_bit;
                        done     <= (bit_cnt_inc == LAST_BIT);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    shift_in     <= 1'b0;
                    frame_active <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

    // Word buffer: loaded pre-shifted at acceptance, then shifted left once per frame bit
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_buf <= {data_sel[WIDTH-2:0], 1'b0};
`ifdef SHIFT_FRAME_PARITY_EN
            parity_q  <= ^data_sel;
`endif
        end else if (state == ST_SHIFT) begin
            shift_buf <= {shift_buf[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Directed bench for shift_frame_arbiter: reset, fairness, a table of single
// frames, mid-frame reset and GAP=0 streaming on a second instance.
`timescale 1ns/1ps
module tb_shift_frame_arbiter;

    localparam int W = 4;
`ifdef SHIFT_FRAME_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif
    localparam int NBB = 2 * L + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data  = '0;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data  = '0;
    logic         req0_ready, req1_ready, shift_in, frame_active, grant, done;

    logic         b_req0_valid = 1'b0;
    logic [W-1:0] b_req0_data  = '0;
    logic         b_req1_valid = 1'b0;
    logic [W-1:0] b_req1_data  = '0;
    logic         b_req0_ready, b_req1_ready, b_shift_in, b_frame_active, b_grant, b_done;

    logic [W-1:0] sr = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_frame_arbiter #(.WIDTH(W), .GAP(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .shift_in(shift_in), .frame_active(frame_active), .grant(grant), .done(done)
    );

    shift_frame_arbiter #(.WIDTH(W), .GAP(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .shift_in(b_shift_in), .frame_active(b_frame_active), .grant(b_grant), .done(b_done)
    );

    // downstream shift register fed by the main instance
    always @(posedge clk) begin
        if (frame_active) sr <= {sr[W-2:0], shift_in};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         who;
        logic [W-1:0] data;
        logic [W-1:0] exp_bits;
        logic         exp_par;
        logic         exp_grant;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          acc_n;
        int          acc_c[4];
        logic        acc_w[4];
        logic [19:0] seen;
        logic [19:0] exp_seen;
        logic [10:0] b_sh, b_fa, exp_b_sh, exp_b_fa;
        int          nb;
        bit          drop, pend_next, got;
        logic        eb;

        tbl[0] = '{1'b0, 4'b1010, 4'b1010, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'b0110, 4'b0110, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 4'b1001, 4'b1001, 1'b0, 1'b1};

        // reset held with both requesters valid
        req0_valid = 1'b1; req0_data = 4'b0011;
        req1_valid = 1'b1; req1_data = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_shift_in", shift_in, 0);
            chk("rst_frame_active", frame_active, 0);
            chk("rst_grant", grant, 0);
            chk("rst_done", done, 0);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_contest_ready0", req0_ready, 1);
        chk("first_contest_ready1", req1_ready, 0);

        // fairness under continuous demand
        acc_n = 0; seen = '0; nb = 0; drop = 0;
        for (int c = 0; c < 100 && nb < 4 * L; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; drop = 0; end
                #1;
            end
            if (req0_ready && req1_ready) chk("fair_both_ready", 1, 0);
            if (frame_active) begin seen = {seen[18:0], shift_in}; nb++; end
            if (acc_n < 4 && (req0_ready || req1_ready)) begin
                acc_c[acc_n] = c;
                acc_w[acc_n] = req1_ready;
                acc_n++;
                if (acc_n == 4) drop = 1;
            end
        end
`ifdef SHIFT_FRAME_PARITY_EN
        exp_seen = 20'b00110_11000_00110_11000;
`else
        exp_seen = 20'h03C3C;
`endif
        chk("fair_accepts", acc_n, 4);
        chk("fair_bits_count", nb, 4 * L);
        chk("fair_bits", seen, exp_seen);
        for (int i = 0; i < acc_n; i++) begin
            chk($sformatf("fair_grant%0d", i), acc_w[i], i % 2);
            if (i > 0) chk($sformatf("fair_period%0d", i), acc_c[i] - acc_c[i-1], L + 2);
        end
        repeat (2) @(negedge clk);

        // single-frame table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tbl[i].who) begin req1_valid = 1'b1; req1_data = tbl[i].data; end
            else begin req0_valid = 1'b1; req0_data = tbl[i].data; end
            #1;
            chk($sformatf("v%0d_ready0", i), req0_ready, !tbl[i].who);
            chk($sformatf("v%0d_ready1", i), req1_ready, tbl[i].who);
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            for (int k = 0; k < L; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                eb = (k < W) ? tbl[i].exp_bits[W-1-k] : tbl[i].exp_par;
                chk($sformatf("v%0d_bit%0d", i, k), shift_in, eb);
                chk($sformatf("v%0d_active%0d", i, k), frame_active, 1);
                chk($sformatf("v%0d_done%0d", i, k), done, k == L - 1);
                chk($sformatf("v%0d_grant%0d", i, k), grant, tbl[i].exp_grant);
            end
            @(negedge clk); #1;
            chk($sformatf("v%0d_after_active", i), frame_active, 0);
            chk($sformatf("v%0d_after_done", i), done, 0);
            chk($sformatf("v%0d_after_shift", i), shift_in, 0);
            chk($sformatf("v%0d_grant_hold", i), grant, tbl[i].exp_grant);
`ifndef SHIFT_FRAME_PARITY_EN
            chk($sformatf("v%0d_sr_out", i), sr, tbl[i].data);
`endif
        end

        // mid-frame reset
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b1001;
        #1;
        chk("mid_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 4'b0101;
        #1;
        chk("mid_bit0", shift_in, 1);
        chk("mid_grant", grant, 0);
        @(negedge clk); #1;
        chk("mid_bit1", shift_in, 0);
        chk("mid_active", frame_active, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_shift_in", shift_in, 0);
        chk("mid_rst_active", frame_active, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b0110;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("post_rst_bit0", shift_in, 0);
        chk("post_rst_active", frame_active, 1);
        chk("post_rst_grant", grant, 0);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (req1_ready) got = 1;
        end
        chk("waiting_req1_served", got, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("req1_grant", grant, 1);
        chk("req1_bit0", shift_in, 0);
        @(negedge clk); #1;
        chk("req1_bit1", shift_in, 1);
        repeat (L + 2) @(negedge clk);

        // GAP=0 streaming on the second instance
        acc_n = 0; nb = 0; b_sh = '0; b_fa = '0; pend_next = 0; drop = 0;
        @(negedge clk);
        b_req1_valid = 1'b1; b_req1_data = 4'b1111;
        #1;
        for (int c = 0; c < 60 && nb < NBB; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (pend_next) begin b_req1_data = 4'b0001; pend_next = 0; end
                if (drop) begin b_req1_valid = 1'b0; drop = 0; end
                #1;
            end
            if (acc_n > 0) begin
                b_sh = {b_sh[9:0], b_shift_in};
                b_fa = {b_fa[9:0], b_frame_active};
                nb++;
            end
            if (acc_n < 2 && b_req1_ready) begin
                acc_c[acc_n] = c;
                acc_n++;
                if (acc_n == 1) pend_next = 1; else drop = 1;
            end
        end
`ifdef SHIFT_FRAME_PARITY_EN
        exp_b_sh = 11'b11110_0_00011;
        exp_b_fa = 11'b11111_0_11111;
`else
        exp_b_sh = 11'b00_1111_0_0001;
        exp_b_fa = 11'b00_1111_0_1111;
`endif
        chk("b2b_accepts", acc_n, 2);
        if (acc_n == 2) chk("b2b_period", acc_c[1] - acc_c[0], L + 1);
        chk("b2b_shift", b_sh, exp_b_sh);
        chk("b2b_active", b_fa, exp_b_fa);
        chk("b2b_grant", b_grant, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_frame_arbiter.md
# shift_frame_arbiter

Sequencing controller for the serial shift register datapath. It accepts parallel words from two requesters over valid/ready handshakes and arbitrates between them round-robin. It serializes the granted word MSB-first onto the `shift_in` line of the downstream shift register, one bit per clock, with framing and completion flags. It sits directly upstream of the shift register and is its only driver.

## Interface
- `WIDTH`, default 4: word and shift-register width; legal range is 2 to 16.
- `GAP`, default 1: idle cycles inserted after each frame; legal range is 0 to 15.

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `req0_valid`, input, 1: requester 0 has a word.
- `req0_data`, input, WIDTH: requester 0 word.
- `req0_ready`, output, 1: requester 0 word accepted this cycle.
- `req1_valid`, input, 1: requester 1 has a word.
- `req1_data`, input, WIDTH: requester 1 word.
- `req1_ready`, output, 1: requester 1 word accepted this cycle.
- `shift_in`, output, 1: serial bit to the shift register; registered.
- `frame_active`, output, 1: `shift_in` carries a frame bit this cycle; registered.
- `grant`, output, 1: owner of the current or last frame; registered.
- `done`, output, 1: one-cycle pulse on the final bit of a frame; registered.

## Operation
- States and transitions:
  - IDLE -> SHIFT on acceptance.
  - SHIFT -> GAP after the final frame bit when GAP>0.
  - SHIFT -> IDLE after the final frame bit when GAP=0.
  - GAP -> IDLE after GAP cycles.
- Arbitration happens in IDLE only.
  - If exactly one requester has valid=1, it is selected.
  - If both have valid=1, the requester other than `last_grant` is selected.
  - `last_grant` resets to 1, so requester 0 wins the first contest.
- `reqN_ready` is combinational: it is 1 only in IDLE and only for the selected requester. Ready depends on valid.
- A transfer is valid&&ready at a rising edge. On that edge:
  - the word is latched into an internal shift buffer;
  - `grant` and `last_grant` are set to N;
  - the bit counter is cleared;
  - the state moves to SHIFT.
- Requesters hold valid and data stable until ready. The losing requester keeps waiting and is never dropped.
- SHIFT:
  - `shift_in` is the buffer MSB and `frame_active` is 1.
  - The buffer shifts left by 1 each cycle and the counter increments.
  - Data occupies WIDTH cycles.
- `done` is 1 in the cycle carrying the final frame bit.
- Outside SHIFT, `shift_in`, `frame_active` and `done` are 0.
- `grant` holds its value until the next acceptance.
- The counter is $clog2(WIDTH+2) bits wide; it never wraps within a frame.
- Reset asserted mid-operation:
  - all outputs go to 0 asynchronously and the state returns to IDLE;
  - the word in flight is discarded, with no retry;
  - `last_grant` is set to 1.

## Timing
- Reset values: `shift_in`=0, `frame_active`=0, `grant`=0, `done`=0; the ready outputs are 0 while `rst`=1.
- Latency: the first bit appears in the cycle after the acceptance edge.
- Frame length is L=WIDTH, or WIDTH+1 with parity enabled.
- Accept-to-accept period under continuous demand is L+GAP+1 cycles, including one IDLE cycle.
- The downstream shift register holds the full word (`out`==word) at the edge ending the `done` cycle, i.e. one cycle after `done` is first seen.
- Simultaneous valid rises on both requesters in IDLE: exactly one ready is asserted, never both.

## Configuration
- `SHIFT_FRAME_PARITY_EN` defined:
  - after the WIDTH data bits, one extra SHIFT cycle drives the even-parity bit (XOR of all data bits) with `frame_active`=1;
  - `done` moves to the parity cycle;
  - L=WIDTH+1.
- `SHIFT_FRAME_PARITY_EN` undefined: L=WIDTH and no parity logic is present.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with both valids high -> all outputs 0 and both readys 0. After release, req0 is granted first.
- **Single word:** req0 only, 4'b1010 -> `req0_ready`=1 in the accept cycle. `shift_in`=1,0,1,0 over the next 4 cycles with `frame_active`=1 and `done` on the 4th. `grant`=0. Shift register `out`=4'b1010 one cycle later.
- **Fairness:** both valid continuously, req0=4'b0011, req1=4'b1100, GAP=1 -> grants 0,1,0,1. Frames 0011,1100,0011,1100 with accepts 6 cycles apart.
- **Back-to-back:** GAP=0, req1 streaming 4'b1111 then 4'b0001 -> the second accept comes 5 cycles after the first. `shift_in`=1,1,1,1,0,0,0,0,1 with exactly one IDLE slot between frames.
- **Mid-frame reset:** req0=4'b1001, assert `rst` after 2 bits -> `shift_in`, `frame_active`, `done` and `grant` go to 0 without waiting for a clock. After release, the still-valid req1 and req0 contend and req0 wins.
- **Parity** (`SHIFT_FRAME_PARITY_EN`): req0=4'b1011 -> `shift_in`=1,0,1,1,1 with `done` on the 5th bit. For 4'b1001, the parity bit is 0.
